// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: reset PC, bubble encoding
// and the fetch request-tracking state.
package mips_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  // IDLE: nothing outstanding; WAIT: one right-path request outstanding;
  // DROP: one wrong-path request outstanding, its response is discarded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Instruction-memory request/response channel of the fetch stage.
interface fetch_redirect_unit_if #(
  parameter int WIDTH = 32
);
  logic             IReqF;
  logic [WIDTH-1:0] IAddrF;
  logic             IAckF;
  logic             IRspValidF;
  logic [WIDTH-1:0] IRDataF;

  modport master (
    output IReqF, IAddrF,
    input  IAckF, IRspValidF, IRDataF
  );

  modport slave (
    input  IReqF, IAddrF,
    output IAckF, IRspValidF, IRDataF
  );
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a returning instruction while decode is stalled.
module fetch_hold_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] instr_i,
  input  logic [WIDTH-1:0] pcplus4_i,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pcplus4_o,
  output logic             valid_o
);
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pcplus4_q;
  logic             valid_q;

  // Clear/pop take priority over load; the top never loads while occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (clear_i || pop_i) begin
      valid_q   <= 1'b0;
    end else if (load_i) begin
      instr_q   <= instr_i;
      pcplus4_q <= pcplus4_i;
      valid_q   <= 1'b1;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;
endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC, single-outstanding instruction-memory requester, wrong-path
// squash and IF/ID pipeline register.
module fetch_redirect_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  PCSrcD,
  input  logic [WIDTH-1:0]      PCBranchD,
  fetch_redirect_unit_if.master imem,
  output logic [WIDTH-1:0]      PCF,
  output logic [WIDTH-1:0]      InstrD,
  output logic [WIDTH-1:0]      PCPlus4D,
  output logic                  ValidD
);
  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pcf_q, pcf_d;
  logic [WIDTH-1:0] req_pc4_q, req_pc4_d;
  logic [WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
  logic             ifid_valid_q, ifid_valid_d;

  logic             redirect, rsp_live, ireq, xfer;
  logic             hb_load, hb_pop, hb_valid;
  logic [WIDTH-1:0] hb_instr, hb_pc4;

  // Handshake decode; a stalled decode defers any redirect until it resumes.
  always_comb begin
    redirect = PCSrcD && !StallD;
    rsp_live = (state_q == WAIT) && imem.IRspValidF && !redirect;
    ireq     = !StallF && !redirect && !hb_valid &&
               ((state_q == IDLE) ||
                ((state_q == WAIT) && imem.IRspValidF && !StallD));
    xfer     = ireq && imem.IAckF;
    hb_load  = rsp_live && (StallD || hb_valid);
    hb_pop   = !StallD && !redirect && hb_valid;
  end

  // Next state, PC and IF/ID contents.
  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    req_pc4_d    = req_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    if (redirect) begin
      pcf_d = PCBranchD;
      case (state_q)
        WAIT:    state_d = imem.IRspValidF ? IDLE : DROP;
        DROP:    state_d = imem.IRspValidF ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else if (xfer) begin
      state_d   = WAIT;
      pcf_d     = pcf_q + WIDTH'(4);
      req_pc4_d = pcf_q + WIDTH'(4);
    end else begin
      case (state_q)
        WAIT:    state_d = imem.IRspValidF ? IDLE : WAIT;
        DROP:    state_d = imem.IRspValidF ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end

    if (redirect) begin
      ifid_instr_d = WIDTH'(NOP_INSTR);
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
    end else if (!StallD) begin
      if (hb_valid) begin
        ifid_instr_d = hb_instr;
        ifid_pc4_d   = hb_pc4;
        ifid_valid_d = 1'b1;
      end else if (rsp_live) begin
        ifid_instr_d = imem.IRDataF;
        ifid_pc4_d   = req_pc4_q;
        ifid_valid_d = 1'b1;
      end else begin
        ifid_instr_d = WIDTH'(NOP_INSTR);
        ifid_pc4_d   = '0;
        ifid_valid_d = 1'b0;
      end
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pcf_q        <= RESET_PC;
      req_pc4_q    <= '0;
      ifid_instr_q <= WIDTH'(NOP_INSTR);
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      req_pc4_q    <= req_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  fetch_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (hb_load),
    .clear_i   (redirect),
    .pop_i     (hb_pop),
    .instr_i   (imem.IRDataF),
    .pcplus4_i (req_pc4_q),
    .instr_o   (hb_instr),
    .pcplus4_o (hb_pc4),
    .valid_o   (hb_valid)
  );

  assign imem.IReqF  = ireq;
  assign imem.IAddrF = pcf_q;
  assign PCF         = pcf_q;
  assign InstrD      = ifid_instr_q;
  assign PCPlus4D    = ifid_pc4_q;
  assign ValidD      = ifid_valid_q;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scoreboard bench for fetch_redirect_unit with a single-outstanding
// instruction memory model of configurable latency.
module tb_fetch_redirect_unit;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, StallD, PCSrcD;
  logic [31:0] PCBranchD;
  logic [31:0] PCF, InstrD, PCPlus4D;
  logic        ValidD;

  fetch_redirect_unit_if #(.WIDTH(32)) bus ();

  fetch_redirect_unit #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallF    (StallF),
    .StallD    (StallD),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .imem      (bus.master),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  logic [31:0] exp_pc;
  logic        m_pend;
  logic [31:0] m_addr;
  int          m_cnt;
  int          m_lat;
  bit          m_rand;
  logic        last_ireq;
  logic [31:0] last_iaddr;

  function automatic logic [31:0] mk_instr(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: drive at negedge, observe combinational request,
  // then update memory model and scoreboard after the rising edge.
  task automatic step(input logic sf, input logic sd, input logic ps,
                      input logic [31:0] tgt, input logic ack);
    logic        xfer, redir, rsp;
    logic [31:0] a, i_b, p_b;
    logic        v_b;
    exp_t        e;
    @(negedge clk);
    StallF = sf; StallD = sd; PCSrcD = ps; PCBranchD = tgt;
    bus.IAckF = ack;
    rsp = m_pend && (m_cnt == 0);
    bus.IRspValidF = rsp;
    bus.IRDataF = rsp ? mk_instr(m_addr) : $urandom;
    #1;
    xfer  = bus.IReqF && ack;
    redir = ps && !sd;
    a     = bus.IAddrF;
    last_ireq  = bus.IReqF;
    last_iaddr = bus.IAddrF;
    n_cmp++;
    if (bus.IReqF && m_pend && !rsp) begin
      n_bad++;
      $display("FAIL one_outstanding: IReqF=%b while request pending, required 0", bus.IReqF);
    end
    if (xfer) begin
      n_cmp++;
      if (a !== exp_pc) begin
        n_bad++;
        $display("FAIL iaddr: got %h required %h", a, exp_pc);
      end
    end
    i_b = InstrD; p_b = PCPlus4D; v_b = ValidD;
    @(posedge clk);
    #1;
    if (m_pend && !rsp && m_cnt > 0) m_cnt--;
    if (rsp) m_pend = 1'b0;
    if (xfer) begin
      m_pend = 1'b1;
      m_addr = a;
      m_cnt  = (m_rand ? $urandom_range(1, 4) : m_lat) - 1;
    end
    if (sd) begin
      n_cmp++;
      if (InstrD !== i_b || PCPlus4D !== p_b || ValidD !== v_b) begin
        n_bad++;
        $display("FAIL ifid_hold: got %h/%h/%b required %h/%h/%b",
                 InstrD, PCPlus4D, ValidD, i_b, p_b, v_b);
      end
    end else if (redir) begin
      n_cmp++;
      if (ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus4D !== 32'h0) begin
        n_bad++;
        $display("FAIL redirect_bubble: got %h/%h/%b required 0/0/0",
                 InstrD, PCPlus4D, ValidD);
      end
    end else if (ValidD === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_instr: got %h/%h required none", InstrD, PCPlus4D);
      end else begin
        e = sb.pop_front();
        if (InstrD !== e.instr || PCPlus4D !== e.pc4) begin
          n_bad++;
          $display("FAIL sb_instr: got %h/%h required %h/%h",
                   InstrD, PCPlus4D, e.instr, e.pc4);
        end
      end
    end else begin
      n_cmp++;
      if (ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus4D !== 32'h0) begin
        n_bad++;
        $display("FAIL bubble: got %h/%h/%b required 0/0/0", InstrD, PCPlus4D, ValidD);
      end
    end
    if (redir) sb.delete();
    if (xfer) sb.push_back('{instr: mk_instr(a), pc4: a + 32'd4});
    if (redir) exp_pc = tgt;
    else if (xfer) exp_pc = exp_pc + 32'd4;
    n_cmp++;
    if (PCF !== exp_pc) begin
      n_bad++;
      $display("FAIL pcf: got %h required %h", PCF, exp_pc);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_pc = RST_PC;
    m_pend = 1'b0;
    m_cnt  = 0;
    bus.IRspValidF = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = '0;
    bus.IAckF = 1'b0; bus.IRDataF = '0;
    m_lat = 1; m_rand = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (PCF !== RST_PC) begin n_bad++; $display("FAIL reset_pcf: got %h required %h", PCF, RST_PC); end
    n_cmp++;
    if (InstrD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ifid: got %h/%h/%b required 0/0/0", InstrD, PCPlus4D, ValidD);
    end
    n_cmp++;
    if (bus.IReqF !== 1'b1) begin n_bad++; $display("FAIL reset_ireq: got %b required 1", bus.IReqF); end
  endtask

  task automatic test_stream();
    m_lat = 1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      if (i < 3) begin
        n_cmp++;
        if (last_iaddr !== RST_PC + 32'(4 * i) || last_ireq !== 1'b1) begin
          n_bad++;
          $display("FAIL stream_addr: got %h/%b required %h/1", last_iaddr, last_ireq,
                   RST_PC + 32'(4 * i));
        end
      end
      if (i == 1) begin
        n_cmp++;
        if (ValidD !== 1'b1 || PCPlus4D !== 32'hBFC0_0004) begin
          n_bad++;
          $display("FAIL stream_first: got %b/%h required 1/bfc00004", ValidD, PCPlus4D);
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d undelivered required 0", sb.size());
    end
  endtask

  task automatic test_redirect();
    m_lat = 4;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (last_ireq !== 1'b0) begin n_bad++; $display("FAIL drop_ireq: got %b required 0", last_ireq); end
    end
    m_lat = 1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (last_ireq !== 1'b1 || last_iaddr !== 32'h0000_0100) begin
      n_bad++;
      $display("FAIL redirect_target: got %b/%h required 1/00000100", last_ireq, last_iaddr);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    drain();
  endtask

  task automatic test_stall_d();
    logic [31:0] a0;
    m_lat = 1;
    a0 = exp_pc;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (last_ireq !== 1'b0) begin n_bad++; $display("FAIL stall_ireq: got %b required 0", last_ireq); end
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (InstrD !== mk_instr(a0) || ValidD !== 1'b1) begin
      n_bad++;
      $display("FAIL hb_release: got %h/%b required %h/1", InstrD, ValidD, mk_instr(a0));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    drain();
  endtask

  task automatic test_pcsrc_stalled();
    logic [31:0] pc0;
    pc0 = PCF;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
    n_cmp++;
    if (PCF !== pc0) begin n_bad++; $display("FAIL pcsrc_stalled: got %h required %h", PCF, pc0); end
    step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
    n_cmp++;
    if (PCF !== 32'h0000_0200) begin n_bad++; $display("FAIL pcsrc_taken: got %h required 00000200", PCF); end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    drain();
  endtask

  task automatic test_random();
    logic        sf, sd, ps, ack;
    logic [31:0] tgt;
    m_rand = 1;
    for (int i = 0; i < 400; i++) begin
      sf  = ($urandom % 4) == 0;
      sd  = ($urandom % 4) == 0;
      ps  = ($urandom % 12) == 0;
      ack = ($urandom % 3) != 0;
      tgt = (($urandom % 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step(sf, sd, ps, tgt, ack);
    end
    m_rand = 0;
    drain();
  endtask

  task automatic test_async_reset();
    m_lat = 1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    m_lat = 4;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (ValidD !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid: got %b required 1", ValidD); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (PCF !== RST_PC || InstrD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got %h/%h/%h/%b required %h/0/0/0",
               PCF, InstrD, PCPlus4D, ValidD, RST_PC);
    end
    StallF = 1'b1;
    model_reset();
    m_lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_stream();
    drain();
    test_redirect();
    test_stall_d();
    test_pcsrc_stalled();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
